// File: rtl/dmem_mmio_responder_if.sv
// CPU data-port bus plus the TX drain port and timer interrupt of the responder.
// The master modport is the CPU/sink side and the slave modport is the responder.
interface dmem_mmio_responder_if;
    logic        MemWrite;
    logic [31:0] Mem_WrAddr;
    logic [31:0] Mem_WrData;
    logic [31:0] ReadData;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic        timer_irq;

    modport master (
        output MemWrite, Mem_WrAddr, Mem_WrData, tx_ready,
        input  ReadData, tx_data, tx_valid, timer_irq
    );

    modport slave (
        input  MemWrite, Mem_WrAddr, Mem_WrData, tx_ready,
        output ReadData, tx_data, tx_valid, timer_irq
    );
endinterface

// File: rtl/dmem_mmio_responder.sv
// Data-port responder: word RAM below 0x8000_0000, and an MMIO block above it.
// The MMIO block holds a byte TX FIFO, a free-running timer and a compare interrupt.
module dmem_mmio_responder #(
    parameter int RAM_WORDS  = 64,
    parameter int FIFO_DEPTH = 8
) (
    input logic                   clk,
    input logic                   reset,
    dmem_mmio_responder_if.slave  bus
);
    localparam int RAM_AW  = $clog2(RAM_WORDS);
    localparam int FIFO_AW = $clog2(FIFO_DEPTH);
    localparam int CNT_W   = FIFO_AW + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);

    localparam logic [1:0] REG_TX_DATA = 2'd0;
    localparam logic [1:0] REG_STATUS  = 2'd1;
    localparam logic [1:0] REG_TIMER   = 2'd2;
    localparam logic [1:0] REG_TIMECMP = 2'd3;

    logic [31:0]       addr;
    logic [31:0]       wdata;
    logic              is_mmio;
    logic [RAM_AW-1:0] ram_idx;
    logic [1:0]        reg_sel;
    logic              unused_bits;

    assign addr        = bus.Mem_WrAddr;
    assign wdata       = bus.Mem_WrData;
    assign is_mmio     = addr[31];
    assign ram_idx     = addr[RAM_AW+1:2];
    assign reg_sel     = addr[3:2];
    assign unused_bits = ^{addr, wdata};

    logic ram_we, push_req, status_we, timer_we, timecmp_we;
    assign ram_we     = bus.MemWrite && !is_mmio;
    assign push_req   = bus.MemWrite && is_mmio && (reg_sel == REG_TX_DATA);
    assign status_we  = bus.MemWrite && is_mmio && (reg_sel == REG_STATUS);
    assign timer_we   = bus.MemWrite && is_mmio && (reg_sel == REG_TIMER);
    assign timecmp_we = bus.MemWrite && is_mmio && (reg_sel == REG_TIMECMP);

    // ------------------------------------------------------------------ RAM
    logic [31:0] ram_q [RAM_WORDS];

    // NOTE: RAM storage has no reset so it maps onto plain memory; a store
    // coincident with reset still commits here.
    always_ff @(posedge clk) begin
        if (ram_we) begin
            ram_q[ram_idx] <= wdata;
        end
    end

    // -------------------------------------------------------------- TX FIFO
    logic [7:0]         fifo_mem_q [FIFO_DEPTH];
    logic [FIFO_AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [FIFO_AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               overflow_q, overflow_d;
    logic               fifo_empty, fifo_full, pop, push;

    assign fifo_empty = (count_q == '0);
    assign fifo_full  = (count_q == DEPTH_C);
    assign pop        = !fifo_empty && bus.tx_ready;
    // A full FIFO still accepts a byte when the head leaves in the same cycle.
    assign push       = push_req && (!fifo_full || pop);

    always_comb begin
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        count_d    = count_q;
        overflow_d = overflow_q;
        if (pop) begin
            rd_ptr_d = rd_ptr_q + FIFO_AW'(1);
        end
        if (push) begin
            wr_ptr_d = wr_ptr_q + FIFO_AW'(1);
        end
        if (push && !pop) begin
            count_d = count_q + CNT_W'(1);
        end else if (pop && !push) begin
            count_d = count_q - CNT_W'(1);
        end
        if (push_req && !push) begin
            overflow_d = 1'b1;
        end else if (status_we && wdata[3]) begin
            overflow_d = 1'b0;
        end
    end

    // NOTE: sequential state is updated with non-blocking assignments so every
    // register in this block samples the pre-edge values of the others.
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                fifo_mem_q[i] <= '0;
            end
        end else begin
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
            if (push) begin
                fifo_mem_q[wr_ptr_q] <= wdata[7:0];
            end
        end
    end

    // ---------------------------------------------------------------- timer
    logic [31:0] timer_q, timer_d;
    logic [31:0] timecmp_q, timecmp_d;
    logic        irq_q, irq_d;

    assign timer_d   = timer_we ? wdata : timer_q + 32'd1;
    assign timecmp_d = timecmp_we ? wdata : timecmp_q;
    assign irq_d     = (timer_q >= timecmp_q);

    always_ff @(posedge clk) begin
        if (reset) begin
            timer_q   <= '0;
            timecmp_q <= 32'hFFFF_FFFF;
            irq_q     <= 1'b0;
        end else begin
            timer_q   <= timer_d;
            timecmp_q <= timecmp_d;
            irq_q     <= irq_d;
        end
    end

    // ------------------------------------------------------------ read path
    logic [31:0] count_ext;
    logic [3:0]  count_sat;
    logic [31:0] status_word;
    logic [31:0] read_data;

    assign count_ext   = 32'(count_q);
    assign count_sat   = (count_ext > 32'd15) ? 4'hF : count_ext[3:0];
    assign status_word = {24'b0, count_sat, overflow_q, fifo_empty, fifo_full, 1'b0};

    // NOTE: read_data gets a default before the decode so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        read_data = '0;
        if (!is_mmio) begin
            read_data = ram_q[ram_idx];
        end else begin
            case (reg_sel)
                REG_STATUS:  read_data = status_word;
                REG_TIMER:   read_data = timer_q;
                REG_TIMECMP: read_data = timecmp_q;
                default:     read_data = '0;
            endcase
        end
    end

    assign bus.ReadData  = read_data;
    assign bus.tx_data   = fifo_mem_q[rd_ptr_q];
    assign bus.tx_valid  = !fifo_empty;
    assign bus.timer_irq = irq_q;
endmodule

// File: tb/tb_dmem_mmio_responder.sv
// Directed self-checking bench for dmem_mmio_responder (RAM_WORDS=64, FIFO_DEPTH=8).
// Inputs change and outputs are sampled 1 time unit after each rising edge.
module tb_dmem_mmio_responder;
    localparam int RAM_WORDS  = 64;
    localparam int FIFO_DEPTH = 8;

    localparam logic [31:0] A_TXDATA  = 32'h8000_0000;
    localparam logic [31:0] A_STATUS  = 32'h8000_0004;
    localparam logic [31:0] A_TIMER   = 32'h8000_0008;
    localparam logic [31:0] A_TIMECMP = 32'h8000_000C;

    logic clk = 1'b0;
    logic reset;
    int   n_checks = 0;
    int   n_fail   = 0;

    dmem_mmio_responder_if bus_if ();

    dmem_mmio_responder #(
        .RAM_WORDS (RAM_WORDS),
        .FIFO_DEPTH(FIFO_DEPTH)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus_if.slave)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
        bus_if.MemWrite   = 1'b1;
        bus_if.Mem_WrAddr = a;
        bus_if.Mem_WrData = d;
        step();
        bus_if.MemWrite   = 1'b0;
    endtask

    task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
        bus_if.MemWrite   = 1'b0;
        bus_if.Mem_WrAddr = a;
        #1;
        d = bus_if.ReadData;
    endtask

    task automatic test_reset();
        logic [31:0] rd;
        reset = 1'b1;
        repeat (2) step();
        reset = 1'b0;
        n_checks++;
        if (bus_if.tx_valid !== 1'b0) begin
            n_fail++; $display("FAIL reset_tx_valid: got %b expected 0", bus_if.tx_valid);
        end
        n_checks++;
        if (bus_if.tx_data !== 8'h00) begin
            n_fail++; $display("FAIL reset_tx_data: got %h expected 00", bus_if.tx_data);
        end
        n_checks++;
        if (bus_if.timer_irq !== 1'b0) begin
            n_fail++; $display("FAIL reset_irq: got %b expected 0", bus_if.timer_irq);
        end
        bus_read(A_STATUS, rd);
        n_checks++;
        if (rd !== 32'h0000_0004) begin
            n_fail++; $display("FAIL reset_status: got %h expected 00000004", rd);
        end
        bus_read(A_TIMECMP, rd);
        n_checks++;
        if (rd !== 32'hFFFF_FFFF) begin
            n_fail++; $display("FAIL reset_timecmp: got %h expected ffffffff", rd);
        end
        bus_read(A_TIMER, rd);
        n_checks++;
        if (rd !== 32'd0) begin
            n_fail++; $display("FAIL reset_timer: got %h expected 00000000", rd);
        end
        repeat (5) step();
        bus_read(A_TIMER, rd);
        n_checks++;
        if (rd !== 32'd5) begin
            n_fail++; $display("FAIL timer_count5: got %h expected 00000005", rd);
        end
    endtask

    task automatic test_ram();
        logic [31:0] rd;
        bus_write(32'h10, 32'hDEAD_BEEF);
        bus_read(32'h10, rd);
        n_checks++;
        if (rd !== 32'hDEAD_BEEF) begin
            n_fail++; $display("FAIL ram_basic: got %h expected deadbeef", rd);
        end
        bus_write(32'h10 + 4 * RAM_WORDS, 32'h1234_5678);
        bus_read(32'h10, rd);
        n_checks++;
        if (rd !== 32'h1234_5678) begin
            n_fail++; $display("FAIL ram_alias: got %h expected 12345678", rd);
        end
        bus_write(32'h20, 32'h1111_1111);
        bus_if.MemWrite   = 1'b1;
        bus_if.Mem_WrAddr = 32'h20;
        bus_if.Mem_WrData = 32'h2222_2222;
        #1;
        n_checks++;
        if (bus_if.ReadData !== 32'h1111_1111) begin
            n_fail++; $display("FAIL ram_rw_old: got %h expected 11111111", bus_if.ReadData);
        end
        step();
        bus_if.MemWrite = 1'b0;
        #1;
        n_checks++;
        if (bus_if.ReadData !== 32'h2222_2222) begin
            n_fail++; $display("FAIL ram_rw_new: got %h expected 22222222", bus_if.ReadData);
        end
    endtask

    task automatic test_fifo();
        logic [31:0] rd;
        logic [7:0]  exp_bytes [3];
        exp_bytes = '{8'h41, 8'h42, 8'h43};
        bus_if.tx_ready = 1'b0;
        bus_if.MemWrite   = 1'b1;
        bus_if.Mem_WrAddr = A_TXDATA;
        bus_if.Mem_WrData = 32'hABCD_EF41;
        #1;
        n_checks++;
        if (bus_if.tx_valid !== 1'b0) begin
            n_fail++; $display("FAIL fifo_no_bypass: got %b expected 0", bus_if.tx_valid);
        end
        step();
        bus_write(A_TXDATA, 32'h0000_0042);
        bus_write(A_TXDATA, 32'hFFFF_FF43);
        n_checks++;
        if (bus_if.tx_valid !== 1'b1 || bus_if.tx_data !== 8'h41) begin
            n_fail++; $display("FAIL fifo_head: got valid=%b data=%h expected valid=1 data=41",
                               bus_if.tx_valid, bus_if.tx_data);
        end
        bus_read(A_STATUS, rd);
        n_checks++;
        if (rd !== 32'h0000_0030) begin
            n_fail++; $display("FAIL fifo_status3: got %h expected 00000030", rd);
        end
        bus_if.tx_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            n_checks++;
            if (bus_if.tx_valid !== 1'b1 || bus_if.tx_data !== exp_bytes[i]) begin
                n_fail++; $display("FAIL fifo_drain%0d: got valid=%b data=%h expected valid=1 data=%h",
                                   i, bus_if.tx_valid, bus_if.tx_data, exp_bytes[i]);
            end
            step();
        end
        bus_read(A_STATUS, rd);
        n_checks++;
        if (bus_if.tx_valid !== 1'b0 || rd !== 32'h0000_0004) begin
            n_fail++; $display("FAIL fifo_empty: got valid=%b status=%h expected valid=0 status=00000004",
                               bus_if.tx_valid, rd);
        end
        bus_if.tx_ready = 1'b0;
    endtask

    task automatic test_overflow();
        logic [31:0] rd;
        logic [7:0]  exp_bytes [8];
        exp_bytes = '{8'h51, 8'h52, 8'h53, 8'h54, 8'h55, 8'h56, 8'h57, 8'h59};
        bus_if.tx_ready = 1'b0;
        for (int i = 0; i < 9; i++) begin
            bus_write(A_TXDATA, 32'h50 + 32'(i));
        end
        bus_read(A_STATUS, rd);
        n_checks++;
        if (rd !== 32'h0000_008A) begin
            n_fail++; $display("FAIL ovf_status: got %h expected 0000008a", rd);
        end
        bus_write(A_STATUS, 32'h0000_0008);
        bus_read(A_STATUS, rd);
        n_checks++;
        if (rd !== 32'h0000_0082) begin
            n_fail++; $display("FAIL ovf_clear: got %h expected 00000082", rd);
        end
        bus_if.tx_ready = 1'b1;
        bus_write(A_TXDATA, 32'h0000_0059);
        bus_if.tx_ready = 1'b0;
        bus_read(A_STATUS, rd);
        n_checks++;
        if (rd !== 32'h0000_0082) begin
            n_fail++; $display("FAIL full_push_pop: got %h expected 00000082", rd);
        end
        bus_if.tx_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            #1;
            n_checks++;
            if (bus_if.tx_valid !== 1'b1 || bus_if.tx_data !== exp_bytes[i]) begin
                n_fail++; $display("FAIL ovf_drain%0d: got valid=%b data=%h expected valid=1 data=%h",
                                   i, bus_if.tx_valid, bus_if.tx_data, exp_bytes[i]);
            end
            step();
        end
        n_checks++;
        if (bus_if.tx_valid !== 1'b0) begin
            n_fail++; $display("FAIL ovf_drained: got %b expected 0", bus_if.tx_valid);
        end
        bus_if.tx_ready = 1'b0;
    endtask

    task automatic test_timer_wrap();
        logic [31:0] rd;
        logic [31:0] exp_vals [3];
        exp_vals = '{32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'h0000_0000};
        bus_write(A_TIMER, 32'hFFFF_FFFE);
        for (int i = 0; i < 3; i++) begin
            bus_read(A_TIMER, rd);
            n_checks++;
            if (rd !== exp_vals[i]) begin
                n_fail++; $display("FAIL timer_wrap%0d: got %h expected %h", i, rd, exp_vals[i]);
            end
            step();
        end
    endtask

    task automatic test_irq();
        logic [31:0] rd;
        bus_write(A_TIMECMP, 32'd100);
        bus_write(A_TIMER, 32'd95);
        bus_read(A_TIMER, rd);
        n_checks++;
        if (rd !== 32'd95) begin
            n_fail++; $display("FAIL irq_timer95: got %h expected 0000005f", rd);
        end
        repeat (5) step();
        bus_read(A_TIMER, rd);
        n_checks++;
        if (rd !== 32'd100 || bus_if.timer_irq !== 1'b0) begin
            n_fail++; $display("FAIL irq_latency: got timer=%h irq=%b expected timer=00000064 irq=0",
                               rd, bus_if.timer_irq);
        end
        step();
        n_checks++;
        if (bus_if.timer_irq !== 1'b1) begin
            n_fail++; $display("FAIL irq_rise: got %b expected 1", bus_if.timer_irq);
        end
        bus_write(A_TIMECMP, 32'hFFFF_FFFF);
        step();
        n_checks++;
        if (bus_if.timer_irq !== 1'b0) begin
            n_fail++; $display("FAIL irq_fall: got %b expected 0", bus_if.timer_irq);
        end
    endtask

    task automatic test_reset_mid_drain();
        logic [31:0] rd;
        bus_write(A_TIMECMP, 32'd0);
        bus_if.tx_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            bus_write(A_TXDATA, 32'h60 + 32'(i));
        end
        n_checks++;
        if (bus_if.timer_irq !== 1'b1) begin
            n_fail++; $display("FAIL mid_irq_before: got %b expected 1", bus_if.timer_irq);
        end
        bus_if.tx_ready = 1'b1;
        step();
        reset = 1'b1;
        bus_write(32'h30, 32'hCAFE_F00D);
        reset = 1'b0;
        bus_if.tx_ready = 1'b0;
        n_checks++;
        if (bus_if.tx_valid !== 1'b0 || bus_if.timer_irq !== 1'b0) begin
            n_fail++; $display("FAIL mid_outputs: got valid=%b irq=%b expected valid=0 irq=0",
                               bus_if.tx_valid, bus_if.timer_irq);
        end
        bus_read(A_STATUS, rd);
        n_checks++;
        if (rd !== 32'h0000_0004) begin
            n_fail++; $display("FAIL mid_status: got %h expected 00000004", rd);
        end
        bus_read(A_TIMER, rd);
        n_checks++;
        if (rd !== 32'd0) begin
            n_fail++; $display("FAIL mid_timer: got %h expected 00000000", rd);
        end
        bus_read(32'h10, rd);
        n_checks++;
        if (rd !== 32'h1234_5678) begin
            n_fail++; $display("FAIL mid_ram_keep: got %h expected 12345678", rd);
        end
        bus_read(32'h30, rd);
        n_checks++;
        if (rd !== 32'hCAFE_F00D) begin
            n_fail++; $display("FAIL mid_ram_write: got %h expected cafef00d", rd);
        end
    endtask

    initial begin
        reset             = 1'b1;
        bus_if.MemWrite   = 1'b0;
        bus_if.Mem_WrAddr = '0;
        bus_if.Mem_WrData = '0;
        bus_if.tx_ready   = 1'b0;
        test_reset();
        test_ram();
        test_fifo();
        test_overflow();
        test_timer_wrap();
        test_irq();
        test_reset_mid_drain();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/dmem_mmio_responder.md
Name: dmem_mmio_responder

Overview:
Responder for the single-cycle CPU data port. It decodes each word access, with addr[31] selecting the region:
- addr[31]=0: word RAM.
- addr[31]=1: MMIO block holding a byte TX FIFO (valid/ready drain port), a free-running 32-bit timer and a compare interrupt.
Reads are combinational so a load completes in one CPU cycle. All writes commit on the rising clock edge.

Parameters:
RAM_WORDS, 64, data RAM depth in 32-bit words; power of two; RAM_AW = log2(RAM_WORDS)
FIFO_DEPTH, 8, TX FIFO depth in bytes; power of two, >= 2

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-high reset
MemWrite  input  1  store strobe from CPU; write commits at the rising edge while high
Mem_WrAddr  input  32  byte address from CPU; bits [1:0] ignored
Mem_WrData  input  32  store data from CPU
ReadData  output  32  combinational read data for Mem_WrAddr
tx_data  output  8  FIFO head byte
tx_valid  output  1  FIFO non-empty
tx_ready  input  1  sink accepts tx_data this cycle
timer_irq  output  1  registered (timer >= timecmp), unsigned compare

Behaviour:
Address decode:
- addr[31]=0: RAM word index = addr[RAM_AW+1:2]. Upper bits are ignored, so addresses alias and wrap modulo RAM_WORDS.
- addr[31]=1: MMIO register select = addr[3:2]. addr[30:4] ignored.

RAM:
- Combinational read, synchronous write.
- Not reset; contents are X until written.
- Read and write to the same word in one cycle: ReadData shows the old word; the new word is visible from the next cycle.

MMIO register map (offset = addr[3:2]):
- 0 TX_DATA
  - Write: push Mem_WrData[7:0].
  - Read: 0.
- 1 STATUS
  - Read: {24'b0, count[3:0], overflow, empty, full, 1'b0}, i.e. bit1 full, bit2 empty, bit3 overflow, bits[7:4] count.
  - count is saturated to 4 bits; FIFO_DEPTH <= 15 is guaranteed by configuration.
  - Write: Mem_WrData[3]=1 clears overflow; other bits ignored.
- 2 TIMER
  - Read: current timer.
  - Write: timer <= Mem_WrData at the edge; increments from the following edge.
- 3 TIMECMP
  - Read/write full 32 bits.

Timer:
- timer <= timer+1 every cycle, wrapping 0xFFFF_FFFF -> 0.
- A write to TIMER overrides the increment in that cycle.
- timer_irq <= (timer >= timecmp), evaluated on the pre-edge values, so there is one cycle of latency after the condition becomes true.
- Writing TIMECMP above timer deasserts timer_irq on the following edge.

TX FIFO:
- Circular buffer; rd/wr pointers plus count (0..FIFO_DEPTH).
- tx_valid = (count != 0). tx_data = mem[rd_ptr], held stable while tx_valid && !tx_ready.
- Pop when tx_valid && tx_ready.
- Push when a TX_DATA write occurs and (count < FIFO_DEPTH or pop in the same cycle).
- Simultaneous push and pop: count unchanged. This holds when full (push accepted) and when count=1.
- Push while empty: byte appears on tx_data the next cycle; there is no bypass.
- Push while full without a pop: byte dropped, overflow <= 1 (sticky), FIFO unchanged.
- Pointers wrap modulo FIFO_DEPTH.

Reset (synchronous):
- timer=0, timecmp=0xFFFF_FFFF, timer_irq=0.
- FIFO empty: count=0, pointers=0, overflow=0.
- tx_valid=0, tx_data=0 (FIFO storage also cleared).
- ReadData follows decode combinationally.
- Reset asserted mid-operation aborts any push/pop and discards FIFO contents. A write coincident with reset is ignored for MMIO but still commits to RAM.

Test Plan:
- RAM: write 0xDEADBEEF @0x10, then 0x12345678 @0x10+4*RAM_WORDS; read 0x10 -> ReadData=0x12345678 (alias). Same-cycle read/write @0x20 -> old value, new value next cycle.
- FIFO: tx_ready=0, write 0x41,0x42,0x43 to 0x8000_0000 -> tx_valid=1, tx_data=0x41, STATUS count=3. Raise tx_ready -> bytes 0x41,0x42,0x43 on consecutive cycles, then tx_valid=0, STATUS empty=1.
- Overflow: tx_ready=0, push 9 bytes with FIFO_DEPTH=8 -> full=1, overflow=1, 9th byte lost. Write 0x8 to STATUS -> overflow=0. Push while full with tx_ready=1 -> accepted, count stays 8.
- Timer: after reset read 0x8000_0008 on cycle N -> N (counting from the first edge after reset deassert). Write 0xFFFF_FFFE -> reads 0xFFFF_FFFE, 0xFFFF_FFFF, 0x0 on successive cycles.
- IRQ: TIMECMP=100, TIMER=95 -> timer_irq rises on the edge after timer reaches 100. Write TIMECMP=0xFFFF_FFFF -> irq=0 next edge.
- Reset mid-drain: 5 bytes queued, assert reset one cycle -> tx_valid=0, STATUS=0x04, timer=0, timer_irq=0; RAM contents preserved.
